// File: rtl/spi_2_apb.sv
// spi_2_apb: SPI mode-0 slave (MSB first) bridging each cs-low frame
// onto exactly one 32-bit APB read or write.
// Ports: pclk/presetn clock and async active-low reset;
//   scl/cs/mosi/miso SPI slave side, oversampled on pclk;
//   paddr/pprot/psel/penable/pwrite/pwdata/pstrb APB request,
//   pready/prdata/pslverr APB response.
// Optional: define SPI2APB_TIMEOUT_EN to enable the APB access watchdog.
module spi_2_apb #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_CYCLES = 256
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              scl,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] paddr,
    output logic [2:0]        pprot,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    input  logic              pready,
    input  logic [31:0]       prdata,
    input  logic              pslverr
);
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RTURN, RDATA, IGNORE
    } spi_st_t;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_st_t;

    spi_st_t r_spi_st, w_spi_nxt;
    apb_st_t r_apb_st, w_apb_nxt;

    logic [2:0]        r_scl_s, r_cs_s;
    logic [1:0]        r_mosi_s;
    logic [4:0]        r_cnt;
    logic [31:0]       r_rx, r_tx, r_wdata, r_rdata;
    logic [7:0]        r_addr;
    logic              r_is_rd, r_launch, r_miso, r_last_err, r_rd_ok;
    logic              w_rise, w_fall, w_cs_fall, w_cs_rise, w_last;
    logic              w_busy, w_cmd_ok, w_done, w_to, w_rej, w_late;
    logic [31:0]       w_rx_nxt;
    logic [7:0]        w_cmd;
    logic [ADDR_W-1:0] w_paddr;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_scl_s  <= 3'b000;
            r_cs_s   <= 3'b111;
            r_mosi_s <= 2'b00;
        end else begin
            r_scl_s  <= {r_scl_s[1:0], scl};
            r_cs_s   <= {r_cs_s[1:0], cs};
            r_mosi_s <= {r_mosi_s[0], mosi};
        end
    end

    // scl edges only count while the synchronized cs is low
    assign w_cs_fall = r_cs_s[2] & ~r_cs_s[1];
    assign w_cs_rise = ~r_cs_s[2] & r_cs_s[1];
    assign w_rise    = r_scl_s[1] & ~r_scl_s[2] & ~r_cs_s[1];
    assign w_fall    = ~r_scl_s[1] & r_scl_s[2] & ~r_cs_s[1];
    assign w_rx_nxt  = {r_rx[30:0], r_mosi_s[1]};
    assign w_cmd     = w_rx_nxt[7:0];
    assign w_cmd_ok  = (w_cmd == 8'h01) || (w_cmd == 8'h02);
    assign w_busy    = (r_apb_st != A_IDLE);
    assign w_done    = (r_apb_st == A_ACCESS) && pready;
    assign w_rej     = (r_spi_st == CMD) && w_last && w_cmd_ok && w_busy;
    assign w_late    = (r_spi_st == RTURN) && w_last && !r_rd_ok;
    assign w_paddr   = BASE_ADDR + ADDR_W'({r_addr, 2'b00});

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_spi_st <= IDLE;
        else          r_spi_st <= w_spi_nxt;
    end

    always_comb begin
        w_spi_nxt = r_spi_st;
        w_last    = 1'b0;
        unique case (r_spi_st)
            WDATA, RDATA:     w_last = w_rise && (r_cnt == 5'd31);
            CMD, ADDR, RTURN: w_last = w_rise && (r_cnt == 5'd7);
            default:          w_last = 1'b0;
        endcase
        if (w_cs_rise) begin
            w_spi_nxt = IDLE;
        end else begin
            unique case (r_spi_st)
                IDLE:  if (w_cs_fall) w_spi_nxt = CMD;
                CMD:   if (w_last)
                           w_spi_nxt = (w_cmd_ok && !w_busy) ? ADDR : IGNORE;
                ADDR:  if (w_last) w_spi_nxt = r_is_rd ? RTURN : WDATA;
                WDATA: if (w_last) w_spi_nxt = IGNORE;
                RTURN: if (w_last) w_spi_nxt = RDATA;
                RDATA: if (w_last) w_spi_nxt = IGNORE;
                default: w_spi_nxt = r_spi_st;
            endcase
        end
    end

    // r_miso holds the bit on the wire; r_tx holds the bits still to come
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt    <= '0;
            r_rx     <= '0;
            r_tx     <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_is_rd  <= 1'b0;
            r_launch <= 1'b0;
            r_miso   <= 1'b0;
        end else begin
            r_launch <= 1'b0;
            if (r_cs_s[1]) begin
                r_miso <= 1'b0;
            end else if (w_cs_fall && r_spi_st == IDLE) begin
                r_cnt  <= '0;
                r_miso <= 1'b0;
                r_tx   <= {5'b0, r_last_err, w_busy, 25'b0};
            end else begin
                if (w_rise) begin
                    r_rx  <= w_rx_nxt;
                    r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
                end
                if (w_fall) begin
                    r_miso <= (r_spi_st == IGNORE) ? 1'b0 : r_tx[31];
                    r_tx   <= {r_tx[30:0], 1'b0};
                end
                if (w_last) begin
                    unique case (r_spi_st)
                        CMD: r_is_rd <= (w_cmd == 8'h02);
                        ADDR: begin
                            r_addr   <= w_rx_nxt[7:0];
                            r_launch <= r_is_rd;
                        end
                        WDATA: begin
                            r_wdata  <= w_rx_nxt;
                            r_launch <= 1'b1;
                        end
                        RTURN: r_tx <= r_rd_ok ? r_rdata : 32'hFFFF_FFFF;
                        default: r_tx <= r_tx;
                    endcase
                end
            end
        end
    end

`ifdef SPI2APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                   r_to_cnt <= '0;
        else if (r_apb_st != A_ACCESS)  r_to_cnt <= '0;
        else                            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_to = (r_apb_st == A_ACCESS) && !pready &&
                  (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_apb_st <= A_IDLE;
        else          r_apb_st <= w_apb_nxt;
    end

    always_comb begin
        w_apb_nxt = r_apb_st;
        unique case (r_apb_st)
            A_IDLE:   if (r_launch) w_apb_nxt = A_SETUP;
            A_SETUP:  w_apb_nxt = A_ACCESS;
            A_ACCESS: if (pready || w_to) w_apb_nxt = A_IDLE;
            default:  w_apb_nxt = A_IDLE;
        endcase
    end

    // completion ORs the error so a reject seen during the access survives
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= 4'h0;
            r_rdata    <= '0;
            r_rd_ok    <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            if (r_launch && r_apb_st == A_IDLE) begin
                paddr      <= w_paddr;
                pwrite     <= !r_is_rd;
                pwdata     <= r_is_rd ? 32'h0 : r_wdata;
                pstrb      <= r_is_rd ? 4'h0 : 4'hF;
                r_rd_ok    <= 1'b0;
                r_last_err <= 1'b0;
            end
            if (w_done) begin
                if (!pwrite) r_rdata <= prdata;
                r_rd_ok    <= 1'b1;
                r_last_err <= r_last_err | pslverr;
            end
            if (w_to) begin
                r_rdata    <= 32'hFFFF_FFFF;
                r_rd_ok    <= 1'b1;
                r_last_err <= 1'b1;
            end
            if (w_rej || w_late) r_last_err <= 1'b1;
        end
    end

    assign psel    = (r_apb_st != A_IDLE);
    assign penable = (r_apb_st == A_ACCESS);
    assign pprot   = 3'b000;
    assign miso    = r_miso;

endmodule
